// File: rtl/ddma_noc_pkg.sv
// ---------------------------------------------------------------------------
// ddma_noc_pkg
//   Shared types and constants for the DDMA <-> NoC local-port datapath.
//   - rx_state_t    : packet framing states (header, size, payload)
//   - tagged_flit_t : a flit with its start/end-of-packet tags, at the
//                     default 32-bit NoC flit width
//   - HDR_ADDR_MSB  : top bit of the destination address field in a header
//   - LOCAL_PORT    : router port number the PE is attached to
// ---------------------------------------------------------------------------
package ddma_noc_pkg;

  localparam int HDR_ADDR_MSB   = 15;
  localparam int LOCAL_PORT     = 4;
  localparam int NOC_FLIT_WIDTH = 32;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    SIZE    = 2'd1,
    PAYLOAD = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic                      sop;
    logic                      eop;
    logic [NOC_FLIT_WIDTH-1:0] flit;
  } tagged_flit_t;

endpackage

// File: rtl/flit_fifo.sv
// ---------------------------------------------------------------------------
// flit_fifo
//   Register-array synchronous FIFO. The head entry is presented
//   combinationally on rd_data; a written entry is visible the cycle after
//   the push (no write-through bypass).
//   Ports:
//     clock, reset   : clock, asynchronous active-low reset
//     push, wr_data  : write request and data (ignored when full)
//     pop            : advance the head (ignored when empty)
//     rd_data        : head entry
//     count          : occupancy, 0..FIFO_DEPTH
//     full, empty    : occupancy flags from the registered counter
// ---------------------------------------------------------------------------
module flit_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 34
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is cleared on reset so a freshly reset head reads as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

endmodule

// File: rtl/ddma_rx_ingress.sv
// ---------------------------------------------------------------------------
// ddma_rx_ingress
//   Ingress stage between the router local port and the DDMA receive path.
//   Flits arrive under credit flow control, are framed (header, size,
//   payload), tagged with sop/eop, buffered, and streamed to the DDMA over
//   valid/ready.
//   Ports:
//     clock, reset  : clock, asynchronous active-low reset
//     rx, data_i    : flit valid / flit from the router
//     credit_o      : buffer has space; router may send
//     m_valid/m_ready/m_data/m_sop/m_eop : tagged flit stream to the DDMA
//     pkts_pending  : complete packets buffered but not fully drained
//     pkt_count     : total packets fully received (wraps)
//     misroute      : sticky, a header address did not match ADDRESS
// ---------------------------------------------------------------------------
module ddma_rx_ingress
  import ddma_noc_pkg::*;
#(
  parameter int                    FLIT_WIDTH  = 32,
  parameter int                    FIFO_DEPTH  = 16,
  parameter logic [HDR_ADDR_MSB:0] ADDRESS     = '0,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx,
  input  logic [FLIT_WIDTH-1:0]         data_i,
  output logic                          credit_o,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [FLIT_WIDTH-1:0]         m_data,
  output logic                          m_sop,
  output logic                          m_eop,
  output logic [$clog2(FIFO_DEPTH):0]   pkts_pending,
  output logic [COUNT_WIDTH-1:0]        pkt_count,
  output logic                          misroute
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [FLIT_WIDTH-1:0] flit;
  } entry_t;

  entry_t                 wr_entry;
  entry_t                 head;
  logic [PTR_W:0]         fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  rx_state_t              state_reg;
  rx_state_t              state_next;
  logic [FLIT_WIDTH-1:0]  remaining_reg;
  logic [FLIT_WIDTH-1:0]  remaining_next;
  logic                   tag_sop;
  logic                   tag_eop;
  logic                   addr_mismatch;

  logic                   push;
  logic                   pop;
  logic                   push_eop;
  logic                   pop_eop;

  logic [PTR_W:0]         pending_reg;
  logic [COUNT_WIDTH-1:0] pkt_count_reg;
  logic                   misroute_reg;

  // Credit comes straight from the registered occupancy, so a pop in one
  // cycle reopens credit in the next.
  assign credit_o = (fifo_count < (PTR_W+1)'(FIFO_DEPTH));
  // Identical to rx && credit_o; a flit offered without credit is dropped.
  assign push     = rx && !fifo_full;
  assign pop      = m_valid && m_ready;
  assign push_eop = push && tag_eop;
  assign pop_eop  = pop && head.eop;

  assign wr_entry = '{sop: tag_sop, eop: tag_eop, flit: data_i};

  flit_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (FLIT_WIDTH + 2)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Outputs are forced to zero whenever nothing is buffered.
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? head.flit : '0;
  assign m_sop   = m_valid && head.sop;
  assign m_eop   = m_valid && head.eop;

  // Framing decode for the flit currently on data_i; only committed on push.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    tag_sop        = 1'b0;
    tag_eop        = 1'b0;
    addr_mismatch  = 1'b0;
    case (state_reg)
      HDR: begin
        tag_sop       = 1'b1;
        addr_mismatch = (data_i[HDR_ADDR_MSB:0] != ADDRESS);
        state_next    = SIZE;
      end
      SIZE: begin
        remaining_next = data_i;
        // A zero-length packet ends on its size flit.
        if (data_i == '0) begin
          tag_eop    = 1'b1;
          state_next = HDR;
        end else begin
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        remaining_next = remaining_reg - FLIT_WIDTH'(1);
        if (remaining_reg == FLIT_WIDTH'(1)) begin
          tag_eop    = 1'b1;
          state_next = HDR;
        end
      end
      default: begin
        state_next = HDR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= HDR;
      remaining_reg <= '0;
      misroute_reg  <= 1'b0;
    end else if (push) begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      if (addr_mismatch) misroute_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_count_reg <= '0;
      pending_reg   <= '0;
    end else begin
      if (push_eop) pkt_count_reg <= pkt_count_reg + 1'b1;
      // A packet completing on input while another leaves the buffer
      // leaves the pending count unchanged.
      case ({push_eop, pop_eop})
        2'b10:   pending_reg <= pending_reg + 1'b1;
        2'b01:   pending_reg <= pending_reg - 1'b1;
        default: pending_reg <= pending_reg;
      endcase
    end
  end

  assign pkts_pending = pending_reg;
  assign pkt_count    = pkt_count_reg;
  assign misroute     = misroute_reg;

endmodule

// File: tb/tb_ddma_rx_ingress.sv
module tb_ddma_rx_ingress;
  import ddma_noc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] data_i;
  logic        credit_o;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_sop;
  logic        m_eop;
  logic [4:0]  pkts_pending;
  logic [15:0] pkt_count;
  logic        misroute;

  tagged_flit_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  ddma_rx_ingress #(
    .FLIT_WIDTH  (32),
    .FIFO_DEPTH  (16),
    .ADDRESS     (16'h0000),
    .COUNT_WIDTH (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .data_i       (data_i),
    .credit_o     (credit_o),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sop        (m_sop),
    .m_eop        (m_eop),
    .pkts_pending (pkts_pending),
    .pkt_count    (pkt_count),
    .misroute     (misroute)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one flit for one cycle and record what the DDMA should see.
  task automatic send(input logic [31:0] d, input logic s, input logic e);
    rx     = 1'b1;
    data_i = d;
    exp_q.push_back(tagged_flit_t'{sop: s, eop: e, flit: d});
    tick();
    rx     = 1'b0;
    data_i = '0;
  endtask

  task automatic drain(input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < 64 && m_valid; i++) tick();
    check({tag, "_drained"}, 64'(m_valid), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: a handshake completes at the next rising edge, so inspect
  // the stable head on the falling edge before it.
  always @(negedge clock) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {31'd0, m_sop, m_eop, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        tagged_flit_t e;
        e = exp_q.pop_front();
        check("pop_flit", {31'd0, m_sop, m_eop, m_data}, {31'd0, e.sop, e.eop, e.flit});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    rx      = 1'b0;
    data_i  = '0;
    m_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    check("rst_credit",   64'(credit_o),     64'd1);
    check("rst_valid",    64'(m_valid),      64'd0);
    check("rst_data",     64'(m_data),       64'd0);
    check("rst_sop_eop",  {62'd0, m_sop, m_eop}, 64'd0);
    check("rst_pending",  64'(pkts_pending), 64'd0);
    check("rst_count",    64'(pkt_count),    64'd0);
    check("rst_misroute", 64'(misroute),     64'd0);
    reset = 1'b1;
    tick();

    // T1: basic packet {0,3,A,B,C}
    m_ready = 1'b1;
    check("t1_idle_valid", 64'(m_valid), 64'd0);
    send(32'h0000_0000, 1'b1, 1'b0);
    check("t1_latency_valid", 64'(m_valid), 64'd1);
    check("t1_first_sop", 64'(m_sop), 64'd1);
    send(32'h0000_0003, 1'b0, 1'b0);
    send(32'h0000_000A, 1'b0, 1'b0);
    send(32'h0000_000B, 1'b0, 1'b0);
    send(32'h0000_000C, 1'b0, 1'b1);
    check("t1_pkt_count", 64'(pkt_count), 64'd1);
    check("t1_last_eop", 64'(m_eop), 64'd1);
    tick();
    check("t1_pending", 64'(pkts_pending), 64'd0);
    check("t1_misroute", 64'(misroute), 64'd0);
    drain("t1");

    // T2: fill the buffer with a 14-payload packet while stalled
    m_ready = 1'b0;
    send(32'h0000_0000, 1'b1, 1'b0);
    send(32'd14, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) send(32'h1000 + i, 1'b0, 1'b0);
    check("t2_credit_15", 64'(credit_o), 64'd1);
    send(32'h1000 + 13, 1'b0, 1'b1);
    check("t2_credit_full", 64'(credit_o), 64'd0);
    check("t2_pending_full", 64'(pkts_pending), 64'd1);
    check("t2_pkt_count", 64'(pkt_count), 64'd2);
    rx     = 1'b1;               // 17th flit without credit: dropped
    data_i = 32'h0000_DEAD;
    tick();
    rx     = 1'b0;
    data_i = '0;
    check("t2_credit_still_low", 64'(credit_o), 64'd0);
    check("t2_pkt_count_after_drop", 64'(pkt_count), 64'd2);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("t2_credit_after_pop", 64'(credit_o), 64'd1);
    drain("t2");
    check("t2_pending_drained", 64'(pkts_pending), 64'd0);

    // T3: size-0 packet
    send(32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b1);
    check("t3_pkt_count", 64'(pkt_count), 64'd3);
    drain("t3");

    // T4: misrouted header
    send(32'h0000_0005, 1'b1, 1'b0);
    check("t4_misroute_set", 64'(misroute), 64'd1);
    send(32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0077, 1'b0, 1'b1);
    drain("t4");
    check("t4_misroute_sticky", 64'(misroute), 64'd1);
    check("t4_pkt_count", 64'(pkt_count), 64'd4);

    // T5: back-to-back size-0 packets at full throughput with a
    // two-entry backlog so eop pushes and eop pops coincide
    m_ready = 1'b0;
    send(32'h0010_0000, 1'b1, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b1);
    check("t5_pending_start", 64'(pkts_pending), 64'd1);
    m_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(32'h0020_0000 + (k << 20), 1'b1, 1'b0);
      check("t5_pending_hdr", 64'(pkts_pending), 64'd1);
      send(32'h0000_0000, 1'b0, 1'b1);
      check("t5_pending_eop_coincide", 64'(pkts_pending), 64'd1);
    end
    drain("t5");
    check("t5_pending_end", 64'(pkts_pending), 64'd0);
    check("t5_pkt_count", 64'(pkt_count), 64'd12);

    // T6: reset mid-payload, then a fresh packet
    m_ready = 1'b0;
    send(32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_0005, 1'b0, 1'b0);
    send(32'h0000_0101, 1'b0, 1'b0);
    send(32'h0000_0102, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_valid",    64'(m_valid),      64'd0);
    check("t6_rst_data",     64'(m_data),       64'd0);
    check("t6_rst_credit",   64'(credit_o),     64'd1);
    check("t6_rst_count",    64'(pkt_count),    64'd0);
    check("t6_rst_misroute", 64'(misroute),     64'd0);
    check("t6_rst_pending",  64'(pkts_pending), 64'd0);
    tick();
    reset   = 1'b1;
    tick();
    m_ready = 1'b1;
    send(32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_00EE, 1'b0, 1'b1);
    drain("t6");
    check("t6_pkt_count", 64'(pkt_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
